// File: rtl/imm_gen_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe_if
// Handshake bundle for the pipelined immediate generator.
//   in_valid / in_ready / in_inst       : upstream (fetch) side
//   out_valid / out_ready / out_*        : downstream (ID/EX) side
// Modports:
//   slave  : the immediate generator itself
//   master : whatever drives instructions in and consumes decoded results
// ---------------------------------------------------------------------------
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [31:0]     out_inst;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_inst, out_illegal
    );

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_inst, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
// Pipelined RV32I/RV64I immediate generator (I, SHAMT, S, B, U, J formats)
// with a registered output slot and a one-entry skid buffer.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous flush, drops OUT, SKID and the current input
//   bus    : imm_gen_pipe_if.slave (in_valid/in_ready/in_inst,
//            out_valid/out_ready/out_imm/out_fmt/out_inst/out_illegal)
// Build option:
//   IMM_GEN_ILLEGAL_EN : when defined, out_illegal flags opcodes with no
//                        defined meaning; otherwise out_illegal is tied 0.
// out_fmt encoding: 0 NONE, 1 I, 2 SHAMT, 3 S, 4 B, 5 U, 6 J.
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);
    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_SHAMT = 3'd2;
    localparam logic [2:0] FMT_S     = 3'd3;
    localparam logic [2:0] FMT_B     = 3'd4;
    localparam logic [2:0] FMT_U     = 3'd5;
    localparam logic [2:0] FMT_J     = 3'd6;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;

    assign inst   = bus.in_inst;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    // Combinational decode of the presented word.
    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Only the low SHAMT_W bits form the shift amount, so the
                    // funct7 bits (and inst[25] on RV32) never leak in.
                    dec_imm = {{(XLEN-SHAMT_W){1'b0}}, inst[20 +: SHAMT_W]};
                    dec_fmt = FMT_SHAMT;
                end else begin
                    dec_imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
                    dec_fmt = FMT_I;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                dec_imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
                dec_fmt = FMT_I;
            end
            OPC_STORE: begin
                dec_imm = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
                dec_fmt = FMT_S;
            end
            OPC_BRANCH: begin
                dec_imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25],
                           inst[11:8], 1'b0};
                dec_fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                // Bit 31 is replicated upward, which is a no-op on RV32.
                dec_imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
                dec_fmt = FMT_U;
            end
            OPC_JAL: begin
                dec_imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20],
                           inst[30:21], 1'b0};
                dec_fmt = FMT_J;
            end
            default: begin
                dec_imm = '0;
                dec_fmt = FMT_NONE;
            end
        endcase
    end

    // Handshake state: OUT slot, SKID slot, and a registered in_ready.
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            in_ready_q;
    logic [XLEN-1:0] out_imm_q, skid_imm_q;
    logic [2:0]      out_fmt_q, skid_fmt_q;
    logic [31:0]     out_inst_q, skid_inst_q;
    logic            accept;
    logic            load_out_new, load_out_skid, load_skid;

    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        out_valid_d   = out_valid_q;
        skid_valid_d  = skid_valid_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
            // OUT is free this edge. A full SKID always has priority; an
            // accept cannot coincide with it because in_ready is low then.
            if (skid_valid_q) begin
                load_out_skid = 1'b1;
                out_valid_d   = 1'b1;
                skid_valid_d  = 1'b0;
            end else begin
                load_out_new = accept;
                out_valid_d  = accept;
            end
        end else if (accept) begin
            load_skid    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            // Own flop so in_ready never sees out_ready combinationally.
            in_ready_q   <= !skid_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm_q   <= '0;
            out_fmt_q   <= FMT_NONE;
            out_inst_q  <= '0;
            skid_imm_q  <= '0;
            skid_fmt_q  <= FMT_NONE;
            skid_inst_q <= '0;
        end else begin
            if (load_out_skid) begin
                out_imm_q  <= skid_imm_q;
                out_fmt_q  <= skid_fmt_q;
                out_inst_q <= skid_inst_q;
            end else if (load_out_new) begin
                out_imm_q  <= dec_imm;
                out_fmt_q  <= dec_fmt;
                out_inst_q <= inst;
            end
            if (load_skid) begin
                skid_imm_q  <= dec_imm;
                skid_fmt_q  <= dec_fmt;
                skid_inst_q <= inst;
            end
        end
    end

`ifdef IMM_GEN_ILLEGAL_EN
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    logic dec_ill;
    logic out_ill_q, skid_ill_q;

    always_comb begin
        dec_ill = 1'b1;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_MISC_MEM,
            OPC_SYSTEM: dec_ill = 1'b0;
            default:    dec_ill = 1'b1;
        endcase
        // Compressed / non-32-bit encodings are never legal here.
        if (inst[1:0] != 2'b11) begin
            dec_ill = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ill_q  <= 1'b0;
            skid_ill_q <= 1'b0;
        end else begin
            if (load_out_skid) begin
                out_ill_q <= skid_ill_q;
            end else if (load_out_new) begin
                out_ill_q <= dec_ill;
            end
            if (load_skid) begin
                skid_ill_q <= dec_ill;
            end
        end
    end

    assign bus.out_illegal = out_ill_q;
`else
    assign bus.out_illegal = 1'b0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_imm   = out_imm_q;
    assign bus.out_fmt   = out_fmt_q;
    assign bus.out_inst  = out_inst_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
// Drives an XLEN=32 and an XLEN=64 instance with identical handshake
// stimulus: a table of known encodings, hand-written backpressure / flush /
// reset sequences, then randomized traffic against a reference model.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

`ifdef IMM_GEN_ILLEGAL_EN
    localparam bit ILL_ON = 1'b1;
`else
    localparam bit ILL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic flush;

    imm_gen_pipe_if #(.XLEN(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64)) bus64 ();

    assign bus64.in_valid  = bus32.in_valid;
    assign bus64.in_inst   = bus32.in_inst;
    assign bus64.out_ready = bus32.out_ready;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus32.slave)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus64.slave)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] inst;
    } entry_t;

    typedef struct packed {
        entry_t e32;
        entry_t e64;
    } pair_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    int     checks;
    int     errors;
    vec_t   tbl[$];
    pair_t  sbq[$];
    logic [6:0] opc_tab [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                                 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73, 7'h7F};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [31:0] inst, input logic [31:0] imm32,
                           input logic [63:0] imm64, input logic [2:0] fmt, input logic ill);
        vec_t v;
        v.inst  = inst;
        v.imm32 = imm32;
        v.imm64 = imm64;
        v.fmt   = fmt;
        v.ill   = ill;
        tbl.push_back(v);
    endtask

    // Sign-extend the low 'bits' bits of val.
    function automatic longint sx(input longint val, input int bits);
        longint one;
        longint r;
        one = 1;
        r = val & ((one << bits) - 1);
        if (r >= (one << (bits - 1))) r = r - (one << bits);
        return r;
    endfunction

    // Reference decode built from the field layouts with plain arithmetic.
    function automatic entry_t ref_dec(input logic [31:0] ins, input int xlen);
        entry_t e;
        longint w, v, opc, f3;
        bit legal;
        w = 0;
        w[31:0] = ins;
        opc = w & 127;
        f3  = (w >> 12) & 7;
        v = 0;
        e.fmt = 3'd0;
        legal = 1'b1;
        case (opc)
            'h13: begin
                if (f3 == 1 || f3 == 5) begin
                    e.fmt = 3'd2;
                    v = (w >> 20) & ((xlen == 64) ? 63 : 31);
                end else begin
                    e.fmt = 3'd1;
                    v = sx(w >> 20, 12);
                end
            end
            'h03, 'h67: begin e.fmt = 3'd1; v = sx(w >> 20, 12); end
            'h23: begin e.fmt = 3'd3; v = sx(((w >> 25) << 5) | ((w >> 7) & 31), 12); end
            'h63: begin
                e.fmt = 3'd4;
                v = sx((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                       (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
            end
            'h37, 'h17: begin e.fmt = 3'd5; v = sx(w & 'hFFFFF000, 32); end
            'h6F: begin
                e.fmt = 3'd6;
                v = sx((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                       (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
            end
            'h33, 'h0F, 'h73: begin e.fmt = 3'd0; v = 0; end
            default: legal = 1'b0;
        endcase
        if ((w & 3) != 3) legal = 1'b0;
        e.imm = v;
        if (xlen == 32) e.imm[63:32] = 32'h0;
        e.ill  = !legal;
        e.inst = ins;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[6:0] = opc_tab[$urandom_range(0, 11)];
        return r;
    endfunction

    // Called at the negedge: compare DUT state with the model, then advance
    // the model by what the coming posedge will do.
    task automatic sb_step();
        pair_t p;
        int    n;
        bit    fire, acc;
        n = sbq.size();
        chk("rnd_out_valid32", 64'(bus32.out_valid), 64'(n != 0));
        chk("rnd_in_ready32",  64'(bus32.in_ready),  64'(n < 2));
        chk("rnd_out_valid64", 64'(bus64.out_valid), 64'(n != 0));
        chk("rnd_in_ready64",  64'(bus64.in_ready),  64'(n < 2));
        if (n != 0) begin
            p = sbq[0];
            chk("rnd_imm32",  64'(bus32.out_imm),     p.e32.imm);
            chk("rnd_fmt32",  64'(bus32.out_fmt),     64'(p.e32.fmt));
            chk("rnd_inst32", 64'(bus32.out_inst),    64'(p.e32.inst));
            chk("rnd_ill32",  64'(bus32.out_illegal), 64'(p.e32.ill & ILL_ON));
            chk("rnd_imm64",  bus64.out_imm,          p.e64.imm);
            chk("rnd_fmt64",  64'(bus64.out_fmt),     64'(p.e64.fmt));
            chk("rnd_ill64",  64'(bus64.out_illegal), 64'(p.e64.ill & ILL_ON));
        end
        fire = (n != 0) && bus32.out_ready;
        acc  = bus32.in_valid && (n < 2);
        if (flush) begin
            sbq.delete();
        end else begin
            if (fire) begin
                p = sbq.pop_front();
                $display("txn out inst=%08h imm32=%08h imm64=%016h fmt=%0d",
                         p.e32.inst, p.e32.imm[31:0], p.e64.imm, p.e32.fmt);
            end
            if (acc) begin
                p.e32 = ref_dec(bus32.in_inst, 32);
                p.e64 = ref_dec(bus32.in_inst, 64);
                sbq.push_back(p);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        flush = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.in_inst   = 32'h0;
        bus32.out_ready = 1'b0;

        // Reset state, sampled while reset is held.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid",   64'(bus32.out_valid),   64'h0);
        chk("rst_in_ready",    64'(bus32.in_ready),    64'h1);
        chk("rst_out_imm",     64'(bus32.out_imm),     64'h0);
        chk("rst_out_fmt",     64'(bus32.out_fmt),     64'h0);
        chk("rst_out_inst",    64'(bus32.out_inst),    64'h0);
        chk("rst_out_illegal", 64'(bus32.out_illegal), 64'h0);
        chk("rst_out_valid64", 64'(bus64.out_valid),   64'h0);
        chk("rst_out_imm64",   bus64.out_imm,          64'h0);

        add_vec(32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0);
        add_vec(32'h4030D093, 32'h00000003, 64'h00000000_00000003, 3'd2, 1'b0);
        add_vec(32'hFE000FE3, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFFE, 3'd4, 1'b0);
        add_vec(32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd4, 1'b0);
        add_vec(32'h00208463, 32'h00000008, 64'h00000000_00000008, 3'd4, 1'b0);
        add_vec(32'h0000006F, 32'h00000000, 64'h00000000_00000000, 3'd6, 1'b0);
        add_vec(32'hFFDFF0EF, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd6, 1'b0);
        add_vec(32'h800000B7, 32'h80000000, 64'hFFFFFFFF_80000000, 3'd5, 1'b0);
        add_vec(32'h12345017, 32'h12345000, 64'h00000000_12345000, 3'd5, 1'b0);
        add_vec(32'h00452083, 32'h00000004, 64'h00000000_00000004, 3'd1, 1'b0);
        add_vec(32'h800080E7, 32'hFFFFF800, 64'hFFFFFFFF_FFFFF800, 3'd1, 1'b0);
        add_vec(32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0);
        add_vec(32'h02109093, 32'h00000001, 64'h00000000_00000021, 3'd2, 1'b0);
        add_vec(32'h7FF0E093, 32'h000007FF, 64'h00000000_000007FF, 3'd1, 1'b0);
        add_vec(32'h002081B3, 32'h00000000, 64'h00000000_00000000, 3'd0, 1'b0);
        add_vec(32'h0000000F, 32'h00000000, 64'h00000000_00000000, 3'd0, 1'b0);
        add_vec(32'h00000073, 32'h00000000, 64'h00000000_00000000, 3'd0, 1'b0);
        add_vec(32'h0000007F, 32'h00000000, 64'h00000000_00000000, 3'd0, 1'b1);
        add_vec(32'h00000010, 32'h00000000, 64'h00000000_00000000, 3'd0, 1'b1);

        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single transactions, one-cycle latency.
        foreach (tbl[i]) begin
            tick();
            bus32.in_valid  = 1'b1;
            bus32.in_inst   = tbl[i].inst;
            bus32.out_ready = 1'b1;
            tick();
            bus32.in_valid = 1'b0;
            @(negedge clk);
            chk("tbl_out_valid32", 64'(bus32.out_valid),   64'h1);
            chk("tbl_imm32",       64'(bus32.out_imm),     64'(tbl[i].imm32));
            chk("tbl_fmt32",       64'(bus32.out_fmt),     64'(tbl[i].fmt));
            chk("tbl_inst32",      64'(bus32.out_inst),    64'(tbl[i].inst));
            chk("tbl_ill32",       64'(bus32.out_illegal), 64'(tbl[i].ill & ILL_ON));
            chk("tbl_out_valid64", 64'(bus64.out_valid),   64'h1);
            chk("tbl_imm64",       bus64.out_imm,          tbl[i].imm64);
            chk("tbl_fmt64",       64'(bus64.out_fmt),     64'(tbl[i].fmt));
            chk("tbl_ill64",       64'(bus64.out_illegal), 64'(tbl[i].ill & ILL_ON));
            $display("txn vec %0d inst=%08h imm32=%08h imm64=%016h fmt=%0d ill=%0b",
                     i, bus32.out_inst, bus32.out_imm, bus64.out_imm, bus32.out_fmt,
                     bus32.out_illegal);
        end
        tick();

        // Backpressure: OUT held, SKID fills, third word stalls, then drain.
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_inst   = 32'h00100093;
        tick();
        bus32.in_inst = 32'h00200093;
        @(negedge clk);
        chk("bp_a_valid",    64'(bus32.out_valid), 64'h1);
        chk("bp_a_imm",      64'(bus32.out_imm),   64'h1);
        chk("bp_a_in_ready", 64'(bus32.in_ready),  64'h1);
        tick();
        bus32.in_inst = 32'h00300093;
        @(negedge clk);
        chk("bp_b_imm",      64'(bus32.out_imm),  64'h1);
        chk("bp_b_in_ready", 64'(bus32.in_ready), 64'h0);
        tick();
        bus32.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_stall_imm",      64'(bus32.out_imm),  64'h1);
        chk("bp_stall_inst",     64'(bus32.out_inst), 64'h00100093);
        chk("bp_stall_in_ready", 64'(bus32.in_ready), 64'h0);
        tick();
        @(negedge clk);
        chk("bp_drain1_imm",      64'(bus32.out_imm),  64'h2);
        chk("bp_drain1_in_ready", 64'(bus32.in_ready), 64'h1);
        tick();
        bus32.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drain2_valid", 64'(bus32.out_valid), 64'h1);
        chk("bp_drain2_imm",   64'(bus32.out_imm),   64'h3);
        tick();
        @(negedge clk);
        chk("bp_empty_valid", 64'(bus32.out_valid), 64'h0);

        // Flush with OUT and SKID full, out_ready high and a valid input.
        tick();
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_inst   = 32'h00500093;
        tick();
        bus32.in_inst = 32'h00600093;
        tick();
        bus32.in_inst   = 32'h00700093;
        bus32.out_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("fl_full_valid",    64'(bus32.out_valid), 64'h1);
        chk("fl_full_in_ready", 64'(bus32.in_ready),  64'h0);
        tick();
        flush = 1'b0;
        bus32.in_valid = 1'b0;
        @(negedge clk);
        chk("fl_after_valid",    64'(bus32.out_valid), 64'h0);
        chk("fl_after_in_ready", 64'(bus32.in_ready),  64'h1);
        chk("fl_after_valid64",  64'(bus64.out_valid), 64'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            chk("fl_quiet_valid", 64'(bus32.out_valid), 64'h0);
        end
        // Flush beats an accept into an empty pipe.
        tick();
        bus32.in_valid = 1'b1;
        bus32.in_inst  = 32'h00800093;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus32.in_valid = 1'b0;
        @(negedge clk);
        chk("fl_accept_valid", 64'(bus32.out_valid), 64'h0);
        tick();
        bus32.in_valid = 1'b1;
        bus32.in_inst  = 32'h00900093;
        tick();
        bus32.in_valid = 1'b0;
        @(negedge clk);
        chk("fl_resume_valid", 64'(bus32.out_valid), 64'h1);
        chk("fl_resume_imm",   64'(bus32.out_imm),   64'h9);

        // Randomized traffic against the model.
        tick();
        flush = 1'b1;
        bus32.in_valid = 1'b0;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 600; c++) begin
            bus32.in_valid = ($urandom_range(0, 3) != 0);
            bus32.in_inst  = rand_inst();
            if (((c / 100) % 2) == 1) bus32.out_ready = ($urandom_range(0, 3) == 0);
            else                      bus32.out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            sb_step();
            tick();
        end

        // Asynchronous reset with both slots occupied.
        flush = 1'b1;
        bus32.in_valid = 1'b0;
        tick();
        flush = 1'b0;
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_inst   = 32'h00A00093;
        tick();
        bus32.in_inst = 32'h00B00093;
        tick();
        bus32.in_valid = 1'b0;
        @(negedge clk);
        chk("ar_full_valid",    64'(bus32.out_valid), 64'h1);
        chk("ar_full_in_ready", 64'(bus32.in_ready),  64'h0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_out_valid",   64'(bus32.out_valid), 64'h0);
        chk("ar_in_ready",    64'(bus32.in_ready),  64'h1);
        chk("ar_out_imm",     64'(bus32.out_imm),   64'h0);
        chk("ar_out_fmt",     64'(bus32.out_fmt),   64'h0);
        chk("ar_out_inst",    64'(bus32.out_inst),  64'h0);
        chk("ar_out_valid64", 64'(bus64.out_valid), 64'h0);
        chk("ar_out_imm64",   bus64.out_imm,        64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus32.out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("ar_nothing_left", 64'(bus32.out_valid), 64'h0);
        tick();
        bus32.in_valid = 1'b1;
        bus32.in_inst  = 32'h00C00093;
        tick();
        bus32.in_valid = 1'b0;
        @(negedge clk);
        chk("ar_resume_valid", 64'(bus32.out_valid), 64'h1);
        chk("ar_resume_imm",   64'(bus32.out_imm),   64'hC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
